pool_for_nmcu: RTL

//  Max-pooling stage directly downstream of the NMCU convolution stage.
//  - Consumes the conv output activation array after conv done.
//  - Non-overlapping PxP max-pool (stride = P), one window element per clock.
//  - Writes the reduced map into a local output array for the next layer / writeback.

---
 rtl/pool_for_nmcu.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/pool_for_nmcu.sv
// pool_for_nmcu: non-overlapping PxP signed max-pool stage fed by the NMCU
// convolution result array. One window element is examined per clock and the
// reduced map is written into a local output array in raster order.
// Optional feature macro: POOL_RELU_EN fuses a ReLU onto every written value.
// The default build writes the raw signed maximum.

`default_nettype none

module pool_for_nmcu #(
  parameter int MAX_INPUT_DIM = 15,
  parameter int MAX_POOL_DIM  = 4,
  parameter int DATABUS_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  output logic                            done,
  input  logic [$clog2(MAX_INPUT_DIM):0]  input_width,
  input  logic [$clog2(MAX_INPUT_DIM):0]  input_height,
  input  logic [$clog2(MAX_POOL_DIM):0]   pool_size,
  input  logic signed [DATABUS_WIDTH-1:0] local_activation_in  [MAX_INPUT_DIM][MAX_INPUT_DIM],
  output logic signed [DATABUS_WIDTH-1:0] local_activation_out [MAX_INPUT_DIM][MAX_INPUT_DIM]
);

  localparam int DIM_W = $clog2(MAX_INPUT_DIM) + 1;
  localparam int PS_W  = $clog2(MAX_POOL_DIM) + 1;
  localparam int IDX_W = (MAX_INPUT_DIM > 1) ? $clog2(MAX_INPUT_DIM) : 1;
  localparam int WIN_W = (MAX_POOL_DIM > 1) ? $clog2(MAX_POOL_DIM) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SCAN     = 2'd1,
    NEXT     = 2'd2,
    FINISHED = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [IDX_W-1:0] x_q, x_d;
  logic [IDX_W-1:0] y_q, y_d;
  logic [WIN_W-1:0] i_q, i_d;
  logic [WIN_W-1:0] j_q, j_d;
  logic signed [DATABUS_WIDTH-1:0] max_q, max_d;
  logic done_q, done_d;

  logic signed [DATABUS_WIDTH-1:0] out_q [MAX_INPUT_DIM][MAX_INPUT_DIM];

  logic [PS_W-1:0]  peff;
  logic [DIM_W-1:0] width_clamp;
  logic [DIM_W-1:0] height_clamp;
  logic [DIM_W-1:0] out_w;
  logic [DIM_W-1:0] out_h;
  logic [IDX_W-1:0] row_idx;
  logic [IDX_W-1:0] col_idx;
  logic signed [DATABUS_WIDTH-1:0] elem;
  logic signed [DATABUS_WIDTH-1:0] cand;
  logic signed [DATABUS_WIDTH-1:0] wr_val;
  logic first_elem;
  logic last_i;
  logic last_j;
  logic wr_en;

  // Effective window edge: 0 means 1x1, anything above the supported maximum is clamped.
  always_comb begin
    peff = pool_size;
    if (pool_size == '0) begin
      peff = PS_W'(1);
    end else if (pool_size > PS_W'(MAX_POOL_DIM)) begin
      peff = PS_W'(MAX_POOL_DIM);
    end
  end

  // Output map size; oversized dimensions are clamped so indexing stays inside the array.
  always_comb begin
    width_clamp  = (input_width  > DIM_W'(MAX_INPUT_DIM)) ? DIM_W'(MAX_INPUT_DIM) : input_width;
    height_clamp = (input_height > DIM_W'(MAX_INPUT_DIM)) ? DIM_W'(MAX_INPUT_DIM) : input_height;
    out_w        = width_clamp  / DIM_W'(peff);
    out_h        = height_clamp / DIM_W'(peff);
  end

  // Element currently under the window iterators, plus the running-max candidate.
  always_comb begin
    row_idx    = y_q * IDX_W'(peff) + IDX_W'(i_q);
    col_idx    = x_q * IDX_W'(peff) + IDX_W'(j_q);
    elem       = local_activation_in[row_idx][col_idx];
    first_elem = (i_q == '0) && (j_q == '0);
    last_i     = (i_q == WIN_W'(peff - PS_W'(1)));
    last_j     = (j_q == WIN_W'(peff - PS_W'(1)));
    cand       = max_q;
    if (first_elem || (elem > max_q)) begin
      cand = elem;
    end
`ifdef POOL_RELU_EN
    wr_val = cand[DATABUS_WIDTH-1] ? '0 : cand;
`else
    wr_val = cand;
`endif
  end

  // Next-state, iterator and output-write control for the pooling sequence.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    i_d     = i_q;
    j_d     = j_q;
    max_d   = max_q;
    wr_en   = 1'b0;
    done_d  = (state_q == FINISHED);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          x_d = '0;
          y_d = '0;
          i_d = '0;
          j_d = '0;
          if ((out_w == '0) || (out_h == '0)) begin
            state_d = FINISHED;
          end else begin
            state_d = SCAN;
          end
        end
      end

      SCAN: begin
        max_d = cand;
        if (last_j) begin
          j_d = '0;
          if (last_i) begin
            i_d     = '0;
            wr_en   = 1'b1;
            state_d = NEXT;
          end else begin
            i_d = i_q + WIN_W'(1);
          end
        end else begin
          j_d = j_q + WIN_W'(1);
        end
      end

      NEXT: begin
        if (DIM_W'(x_q) < (out_w - DIM_W'(1))) begin
          x_d     = x_q + IDX_W'(1);
          state_d = SCAN;
        end else if (DIM_W'(y_q) < (out_h - DIM_W'(1))) begin
          x_d     = '0;
          y_d     = y_q + IDX_W'(1);
          state_d = SCAN;
        end else begin
          state_d = FINISHED;
        end
      end

      FINISHED: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control registers: state, iterators, running max and the registered done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      max_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      i_q     <= i_d;
      j_q     <= j_d;
      max_q   <= max_d;
      done_q  <= done_d;
    end
  end

  // Pooled map storage: cleared on reset, one entry written at the end of each window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < MAX_INPUT_DIM; r++) begin
        for (int c = 0; c < MAX_INPUT_DIM; c++) begin
          out_q[r][c] <= '0;
        end
      end
    end else if (wr_en) begin
      out_q[y_q][x_q] <= wr_val;
    end
  end

  assign done                 = done_q;
  assign local_activation_out = out_q;

endmodule

`default_nettype wire
